// File: rtl/fft_r2_stage2.sv
// Second radix-2 stage of the 16-point 2-lane MDC FFT: halving butterfly, W8^k rotation, delay commutator.
// All state advances only on in_valid; out_valid follows a fill of 2*buffer_size+1 accepted pairs.
module fft_r2_stage2 #(
  parameter int width       = 12,
  parameter int buffer_size = 2,
  parameter int frame_pairs = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_frame_start,
  input  logic [width-1:0] a_re,
  input  logic [width-1:0] a_im,
  input  logic [width-1:0] b_re,
  input  logic [width-1:0] b_im,
  output logic             out_valid,
  output logic             out_frame_start,
  output logic [width-1:0] y1_re,
  output logic [width-1:0] y1_im,
  output logic [width-1:0] y2_re,
  output logic [width-1:0] y2_im
);

  localparam int D  = buffer_size;
  localparam int L  = 2 * D + 1;
  localparam int CW = (frame_pairs > 1) ? $clog2(frame_pairs) : 1;
  localparam int PW = $clog2(2 * D);
  localparam int FW = $clog2(L + 1);
  localparam int MW = 2 * width + 2;
  localparam int CI = $rtoi(0.70710678 * (2.0 ** (width - 1)) + 0.5);

  localparam logic signed [MW-1:0] CX   = MW'(CI);
  localparam logic signed [MW-1:0] RND  = MW'(2 ** (width - 2));
  localparam logic signed [MW-1:0] MAXV = MW'(2 ** (width - 1) - 1);
  localparam logic signed [MW-1:0] MINV = MW'(-(2 ** (width - 1)));

  function automatic logic [width-1:0] sat(input logic signed [MW-1:0] x);
    if (x > MAXV)      return MAXV[width-1:0];
    else if (x < MINV) return MINV[width-1:0];
    else               return x[width-1:0];
  endfunction

  // Fixed-point product back to sample scale, rounding half up.
  function automatic logic signed [MW-1:0] rnd(input logic signed [MW-1:0] x);
    return (x + RND) >>> (width - 1);
  endfunction

  logic [CW-1:0]        c_q, c_d, c_eff;
  logic                 first;
  logic [1:0]           k;
  logic [width:0]       sum_re, sum_im, dif_re, dif_im;
  logic [width-1:0]     s_re, s_im, d_re, d_im, r_re_d, r_im_d;
  logic signed [MW-1:0] dr, di, sum_x, dif_x, rr, ri;

  logic [2*width-1:0]   s_q, r_q, dd, mux1, y1_q, y2_q;
  logic [2*width-1:0]   dbuf_q [D];
  logic [2*width-1:0]   ybuf_q [D];
  logic                 fs_q;
  logic [PW-1:0]        p_q, p_eff;
  logic                 sel;
  logic [2*D-1:0]       fs_pipe_q;
  logic [FW-1:0]        fill_q;
  logic                 out_valid_q, out_fs_q;

  always_comb begin
    c_eff = in_frame_start ? '0 : c_q;
    first = (c_eff == '0);
    c_d   = (c_eff == CW'(frame_pairs - 1)) ? '0 : c_eff + CW'(1);
    k     = 2'(c_eff % 4);

    sum_re = {a_re[width-1], a_re} + {b_re[width-1], b_re};
    sum_im = {a_im[width-1], a_im} + {b_im[width-1], b_im};
    dif_re = {a_re[width-1], a_re} - {b_re[width-1], b_re};
    dif_im = {a_im[width-1], a_im} - {b_im[width-1], b_im};
    s_re   = sum_re[width:1];
    s_im   = sum_im[width:1];
    d_re   = dif_re[width:1];
    d_im   = dif_im[width:1];

    dr    = MW'($signed(d_re));
    di    = MW'($signed(d_im));
    sum_x = dr + di;
    dif_x = di - dr;
    case (k)
      2'd0: begin
        rr = dr;
        ri = di;
      end
      2'd1: begin
        rr = rnd(sum_x * CX);
        ri = rnd(dif_x * CX);
      end
      2'd2: begin
        rr = di;
        ri = -dr;
      end
      default: begin
        rr = rnd(dif_x * CX);
        ri = rnd(-sum_x * CX);
      end
    endcase
    r_re_d = sat(rr);
    r_im_d = sat(ri);

    // Commutator phase restarts on the pair that carries the frame flag.
    p_eff = fs_q ? '0 : p_q;
    sel   = (p_eff >= PW'(D));
    dd    = dbuf_q[D-1];
    mux1  = sel ? dd : s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      s_q         <= '0;
      r_q         <= '0;
      fs_q        <= 1'b0;
      p_q         <= '0;
      for (int i = 0; i < D; i++) begin
        dbuf_q[i] <= '0;
        ybuf_q[i] <= '0;
      end
      fs_pipe_q   <= '0;
      fill_q      <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      out_valid_q <= 1'b0;
      out_fs_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_fs_q    <= 1'b0;
      if (in_valid) begin
        c_q       <= c_d;
        s_q       <= {s_re, s_im};
        r_q       <= {r_re_d, r_im_d};
        fs_q      <= first;
        p_q       <= p_eff + PW'(1);
        dbuf_q[0] <= r_q;
        ybuf_q[0] <= mux1;
        for (int i = 1; i < D; i++) begin
          dbuf_q[i] <= dbuf_q[i-1];
          ybuf_q[i] <= ybuf_q[i-1];
        end
        fs_pipe_q <= {fs_pipe_q[2*D-2:0], fs_q};
        if (fill_q < FW'(L)) fill_q <= fill_q + FW'(1);
        out_valid_q <= (fill_q >= FW'(L - 1));
        out_fs_q    <= fs_pipe_q[2*D-1];
        y1_q        <= ybuf_q[D-1];
        y2_q        <= sel ? s_q : dd;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_frame_start = out_fs_q;
  assign y1_re           = y1_q[2*width-1:width];
  assign y1_im           = y1_q[width-1:0];
  assign y2_re           = y2_q[2*width-1:width];
  assign y2_im           = y2_q[width-1:0];

endmodule

// File: tb/tb_fft_r2_stage2.sv
// Bench for fft_r2_stage2: random and directed pairs against an arithmetic reference of the stage.
module tb_fft_r2_stage2;
  localparam int D  = 2;
  localparam int FP = 8;
  localparam int L  = 2 * D + 1;
  localparam int C  = 1448;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_frame_start = 1'b0;
  logic [11:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        out_valid, out_frame_start;
  logic [11:0] y1_re, y1_im, y2_re, y2_im;

  always #5 clk = ~clk;

  fft_r2_stage2 #(.width(12), .buffer_size(D), .frame_pairs(FP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame_start(in_frame_start),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_frame_start(out_frame_start),
    .y1_re(y1_re), .y1_im(y1_im), .y2_re(y2_re), .y2_im(y2_im)
  );

  wire [48:0] obs = {out_frame_start, y1_re, y1_im, y2_re, y2_im};

  int nchk = 0;
  int nfail = 0;

  // Reference state: per accepted pair m, butterfly sum, rotated difference, frame flag.
  int acc, mc, mp;
  int s_re_h [0:4095];
  int s_im_h [0:4095];
  int r_re_h [0:4095];
  int r_im_h [0:4095];
  int x_re_h [0:4095];
  int x_im_h [0:4095];
  bit fl_h   [0:4095];
  logic        exp_valid;
  logic [48:0] exp_dat;

  function automatic int rs();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  function automatic int sat12(int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int rnd11(int x);
    return (x + 1024) >>> 11;
  endfunction

  task automatic model_reset();
    acc = 0; mc = 0; mp = 0;
    s_re_h[0] = 0; s_im_h[0] = 0; r_re_h[0] = 0; r_im_h[0] = 0; fl_h[0] = 1'b0;
    exp_valid = 1'b0; exp_dat = '0;
  endtask

  task automatic drive(input bit v, input bit fs, input int ar, input int ai, input int br, input int bi);
    int m, eff, sr, si, dr, di, rr, ri, pe, cr, ci, ddr, ddi, y1r, y1i, y2r, y2i;
    bit sel, f;
    in_valid = v; in_frame_start = fs;
    a_re = ar[11:0]; a_im = ai[11:0]; b_re = br[11:0]; b_im = bi[11:0];
    @(posedge clk);
    exp_valid = 1'b0;
    if (v) begin
      acc++;
      m   = acc;
      eff = fs ? 0 : mc;
      mc  = (eff + 1) % FP;
      sr = (ar + br) >>> 1; si = (ai + bi) >>> 1;
      dr = (ar - br) >>> 1; di = (ai - bi) >>> 1;
      case (eff % 4)
        0: begin rr = dr; ri = di; end
        1: begin rr = sat12(rnd11((dr + di) * C)); ri = sat12(rnd11((di - dr) * C)); end
        2: begin rr = di; ri = sat12(-dr); end
        default: begin rr = sat12(rnd11((di - dr) * C)); ri = sat12(rnd11(-(dr + di) * C)); end
      endcase
      s_re_h[m] = sr; s_im_h[m] = si; r_re_h[m] = rr; r_im_h[m] = ri; fl_h[m] = (eff == 0);
      // The commutator sees the pair accepted one step earlier.
      pe  = fl_h[m-1] ? 0 : mp;
      sel = (pe >= D);
      mp  = (pe + 1) % (2 * D);
      cr  = s_re_h[m-1]; ci = s_im_h[m-1];
      ddr = (m - 1 - D >= 1) ? r_re_h[m-1-D] : 0;
      ddi = (m - 1 - D >= 1) ? r_im_h[m-1-D] : 0;
      x_re_h[m] = sel ? ddr : cr;
      x_im_h[m] = sel ? ddi : ci;
      y1r = (m - D >= 1) ? x_re_h[m-D] : 0;
      y1i = (m - D >= 1) ? x_im_h[m-D] : 0;
      y2r = sel ? cr : ddr;
      y2i = sel ? ci : ddi;
      f   = (m - L >= 1) ? fl_h[m-L] : 1'b0;
      exp_valid = (m >= L);
      exp_dat   = {f, y1r[11:0], y1i[11:0], y2r[11:0], y2i[11:0]};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nchk++;
    if ({out_valid, obs} !== 50'd0) begin
      nfail++;
      $display("FAIL reset_state got %h expected 0", {out_valid, obs});
    end
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    nchk++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_idle valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_butterfly();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 100, -50, 20, 10);
      else        drive(1'b1, 1'b0, rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL butterfly pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  task automatic test_twiddle();
    for (int i = 0; i < 8; i++) begin
      if (i == 1 || i == 3) drive(1'b1, i == 0, 1000, 0, -1000, 0);
      else                  drive(1'b1, i == 0, rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL twiddle pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) begin
      if (i == 2)          drive(1'b1, 1'b0, 0, -2048, 0, 2047);
      else if (i == 6)     drive(1'b1, 1'b0, -2048, 0, 2047, 0);
      else if (i % 2 == 1) drive(1'b1, 1'b0, 2047, 2047, -2048, -2048);
      else                 drive(1'b1, i == 0, rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL saturation pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(2) == 0) begin
        for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
          drive(1'b0, 1'b1, rs(), rs(), rs(), rs());
          nchk++;
          if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL stall_gap before pair %0d: valid got %b expected 0", i, out_valid);
          end
        end
      end
      drive(1'b1, (i % FP) == 0, rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL stall pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0 || i == 5), rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL resync pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rs(), rs(), rs(), rs());
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({out_valid, obs} !== 50'd0) begin
      nfail++;
      $display("FAIL reset_mid outputs got %h expected 0", {out_valid, obs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1'b1, 1'b0, 1000, 0, -1000, 0);
      else        drive(1'b1, 1'b0, rs(), rs(), rs(), rs());
      nchk++;
      if (out_valid !== exp_valid || (exp_valid && obs !== exp_dat)) begin
        nfail++;
        $display("FAIL reset_mid pair %0d: valid=%b dat=%h expected valid=%b dat=%h", i, out_valid, obs, exp_valid, exp_dat);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_butterfly();
    test_twiddle();
    test_saturation();
    test_stall();
    test_resync();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
